// File: rtl/bcd_entry_keypad.sv
// Three-digit BCD entry keypad front end.
//
// Conditions the raw active-low push button, which is synchronised and then debounced into a
// single-cycle press pulse. Each press then steps a three-digit BCD entry on the switch
// nibble. The digits are entered ones first, then tens, then hundreds. A completed entry is
// published on `value` together with a one-cycle `value_valid` strobe.
//
// Ports:
//   CLOCK_50    - sole clock, rising edge
//   reset       - synchronous, active-high reset
//   key_n       - raw push button, active-low, asynchronous
//   sw          - digit nibble, sampled in the press cycle
//   value       - last committed BCD value {hundreds, tens, ones}
//   value_valid - one-cycle strobe coincident with a new commit
//   entering    - high while a digit is being entered
//   digit_sel   - one-hot active digit (001 ones, 010 tens, 100 hundreds, 000 idle)
//   blink       - toggles every BLINK_CYCLES while entering, 0 when idle
//   entry_error - sticky flag for a non-BCD digit press, cleared at entry start
//   press       - debounced single-cycle press pulse
module bcd_entry_keypad #(
  parameter int unsigned DEBOUNCE_CYCLES = 500_000,
  parameter int unsigned TIMEOUT_CYCLES  = 500_000_000,
  parameter int unsigned BLINK_CYCLES    = 12_500_000
) (
  input  logic        CLOCK_50,
  input  logic        reset,
  input  logic        key_n,
  input  logic [3:0]  sw,
  output logic [11:0] value,
  output logic        value_valid,
  output logic        entering,
  output logic [2:0]  digit_sel,
  output logic        blink,
  output logic        entry_error,
  output logic        press
);

  localparam int unsigned DbW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TmW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned BlW = $clog2(BLINK_CYCLES + 1);

  localparam logic [DbW-1:0] DbLast = DbW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TmW-1:0] TmLast = TmW'(TIMEOUT_CYCLES - 1);
  localparam logic [BlW-1:0] BlLast = BlW'(BLINK_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StD0, StD1, StD2} state_e;

  // ---------------------------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------------------------
  logic           sync1_q, sync2_q;
  logic           stable_q, stable_dly_q;
  logic [DbW-1:0] db_cnt_q;
  logic           press_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      stable_q     <= 1'b0;
      stable_dly_q <= 1'b0;
      db_cnt_q     <= '0;
      press_q      <= 1'b0;
    end else begin
      // Invert at the pin so every later stage sees "pressed" as 1.
      sync1_q      <= ~key_n;
      sync2_q      <= sync1_q;
      stable_dly_q <= stable_q;
      // Emit a pulse on the released->pressed edge only. A release produces nothing.
      press_q      <= stable_q & ~stable_dly_q;
      if (sync2_q != stable_q) begin
        if (db_cnt_q == DbLast) begin
          stable_q <= sync2_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
    end
  end

  assign press = press_q;

  // ---------------------------------------------------------------------------------------------
  // Entry FSM
  // ---------------------------------------------------------------------------------------------
  state_e         state_q, state_d;
  logic [7:0]     shadow_q, shadow_d;
  logic [11:0]    value_q, value_d;
  logic           valid_q, valid_d;
  logic           err_q, err_d;
  logic [TmW-1:0] tmo_q, tmo_d;
  logic           blink_q, blink_d;
  logic [BlW-1:0] bcnt_q, bcnt_d;
  logic           digit_ok;

  assign digit_ok = (sw <= 4'd9);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= StIdle;
      shadow_q <= '0;
      value_q  <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      tmo_q    <= '0;
      blink_q  <= 1'b0;
      bcnt_q   <= '0;
    end else begin
      state_q  <= state_d;
      shadow_q <= shadow_d;
      value_q  <= value_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
      tmo_q    <= tmo_d;
      blink_q  <= blink_d;
      bcnt_q   <= bcnt_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    value_d  = value_q;
    valid_d  = 1'b0;
    err_d    = err_q;
    tmo_d    = tmo_q;
    blink_d  = blink_q;
    bcnt_d   = bcnt_q;

    unique case (state_q)
      StIdle: begin
        blink_d = 1'b0;
        bcnt_d  = '0;
        tmo_d   = '0;
        if (press_q) begin
          state_d  = StD0;
          shadow_d = '0;
          err_d    = 1'b0;
          blink_d  = 1'b1;
        end
      end
      StD0, StD1, StD2: begin
        if (bcnt_q == BlLast) begin
          bcnt_d  = '0;
          blink_d = ~blink_q;
        end else begin
          bcnt_d = bcnt_q + BlW'(1);
        end

        if (press_q && digit_ok) begin
          // A valid digit wins over a coincident timeout expiry.
          tmo_d = '0;
          unique case (state_q)
            StD0: begin
              shadow_d[3:0] = sw;
              state_d       = StD1;
            end
            StD1: begin
              shadow_d[7:4] = sw;
              state_d       = StD2;
            end
            default: begin
              value_d = {sw, shadow_q};
              valid_d = 1'b1;
              state_d = StIdle;
            end
          endcase
        end else begin
          // An invalid press flags the error but does not restart the timeout.
          if (press_q) begin
            err_d = 1'b1;
          end
          if (tmo_q == TmLast) begin
            state_d = StIdle;
            tmo_d   = '0;
          end else begin
            tmo_d = tmo_q + TmW'(1);
          end
        end

        // Blink must already be low in the first IDLE cycle.
        if (state_d == StIdle) begin
          blink_d = 1'b0;
          bcnt_d  = '0;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_comb begin
    digit_sel = 3'b000;
    unique case (state_q)
      StD0:    digit_sel = 3'b001;
      StD1:    digit_sel = 3'b010;
      StD2:    digit_sel = 3'b100;
      default: digit_sel = 3'b000;
    endcase
  end

  assign entering    = (state_q != StIdle);
  assign value       = value_q;
  assign value_valid = valid_q;
  assign entry_error = err_q;
  assign blink       = blink_q;

endmodule

// File: tb/tb_bcd_entry_keypad.sv
// Scoreboard bench for bcd_entry_keypad. Stimulus pushes the expected committed value before
// the final digit press, and a negedge monitor pops and compares on every value_valid strobe.
module tb_bcd_entry_keypad;

  logic        clk = 1'b0;
  logic        reset;
  logic        key_n;
  logic [3:0]  sw;
  logic [11:0] value;
  logic        value_valid;
  logic        entering;
  logic [2:0]  digit_sel;
  logic        blink;
  logic        entry_error;
  logic        press;

  int checks = 0;
  int errors = 0;
  int press_count = 0;
  int strobe_count = 0;
  logic start_pending = 1'b0;
  logic [11:0] exp_q[$];

  bcd_entry_keypad #(
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (200),
    .BLINK_CYCLES   (8)
  ) dut (
    .CLOCK_50   (clk),
    .reset      (reset),
    .key_n      (key_n),
    .sw         (sw),
    .value      (value),
    .value_valid(value_valid),
    .entering   (entering),
    .digit_sel  (digit_sel),
    .blink      (blink),
    .entry_error(entry_error),
    .press      (press)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: press counting, entry-start checks and the scoreboard on value_valid.
  always @(negedge clk) begin
    if (press) press_count++;
    if (start_pending) begin
      check("blink_at_start", 32'(blink), 32'd1);
      check("digit_sel_at_start", 32'(digit_sel), 32'd1);
    end
    start_pending <= press && !entering && !reset;
    if (value_valid) begin
      strobe_count++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got value %0h, expected no strobe", value);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check("commit_value", 32'(value), 32'(e));
        check("entering_at_commit", 32'(entering), 32'd0);
      end
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_key(input logic [3:0] d);
    sw    = d;
    key_n = 1'b0;
    cycles(20);
    key_n = 1'b1;
    cycles(20);
  endtask

  initial begin
    int pc0;
    reset = 1'b1;
    key_n = 1'b1;
    sw    = 4'd0;
    cycles(3);
    check("rst_value", 32'(value), 32'h0);
    check("rst_valid", 32'(value_valid), 32'd0);
    check("rst_entering", 32'(entering), 32'd0);
    check("rst_digit_sel", 32'(digit_sel), 32'd0);
    check("rst_blink", 32'(blink), 32'd0);
    check("rst_error", 32'(entry_error), 32'd0);
    check("rst_press", 32'(press), 32'd0);
    reset = 1'b0;
    cycles(2);

    // Entry of 123: ones, then tens, then hundreds.
    press_key(4'd0);
    check("e123_sel_d0", 32'(digit_sel), 32'b001);
    press_key(4'd3);
    check("e123_sel_d1", 32'(digit_sel), 32'b010);
    press_key(4'd2);
    check("e123_sel_d2", 32'(digit_sel), 32'b100);
    exp_q.push_back(12'h123);
    press_key(4'd1);
    check("e123_sel_idle", 32'(digit_sel), 32'b000);
    check("e123_entering", 32'(entering), 32'd0);
    check("e123_value", 32'(value), 32'h123);
    check("e123_strobes", 32'(strobe_count), 32'd1);

    // Short bounces must not produce a press.
    pc0 = press_count;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      cycles(2);
      key_n = 1'b1;
      cycles(2);
    end
    cycles(10);
    check("bounce_no_press", 32'(press_count), 32'(pc0));
    check("bounce_idle", 32'(entering), 32'd0);
    key_n = 1'b0;
    cycles(10);
    key_n = 1'b1;
    cycles(20);
    check("clean_one_press", 32'(press_count), 32'(pc0 + 1));
    check("clean_enters_d0", 32'(digit_sel), 32'b001);

    // Error path from D1.
    press_key(4'd5);
    check("err_in_d1", 32'(digit_sel), 32'b010);
    press_key(4'hA);
    check("err_flag", 32'(entry_error), 32'd1);
    check("err_stay_d1", 32'(digit_sel), 32'b010);
    check("err_value_kept", 32'(value), 32'h123);
    press_key(4'd7);
    check("err_to_d2", 32'(digit_sel), 32'b100);
    check("err_sticky", 32'(entry_error), 32'd1);
    cycles(220);
    check("err_timeout_idle", 32'(entering), 32'd0);
    check("err_timeout_kept", 32'(entry_error), 32'd1);
    press_key(4'd0);
    check("err_cleared", 32'(entry_error), 32'd0);

    // One valid digit, then timeout: no commit.
    press_key(4'd9);
    check("tmo_in_d1", 32'(digit_sel), 32'b010);
    cycles(210);
    check("tmo_entering", 32'(entering), 32'd0);
    check("tmo_value", 32'(value), 32'h123);
    check("tmo_sel", 32'(digit_sel), 32'b000);

    // Reset asserted in D2.
    press_key(4'd0);
    press_key(4'd1);
    press_key(4'd2);
    check("rst_d2_sel", 32'(digit_sel), 32'b100);
    reset = 1'b1;
    cycles(1);
    check("rst_d2_value", 32'(value), 32'h0);
    check("rst_d2_digit_sel", 32'(digit_sel), 32'd0);
    check("rst_d2_entering", 32'(entering), 32'd0);
    check("rst_d2_valid", 32'(value_valid), 32'd0);
    reset = 1'b0;
    cycles(5);

    // Back-to-back entries.
    press_key(4'd0);
    press_key(4'd5);
    press_key(4'd7);
    exp_q.push_back(12'h875);
    press_key(4'd8);
    check("b2b_875", 32'(value), 32'h875);
    press_key(4'd0);
    press_key(4'd0);
    press_key(4'd4);
    exp_q.push_back(12'h440);
    press_key(4'd4);
    check("b2b_440", 32'(value), 32'h440);
    cycles(5);
    check("total_strobes", 32'(strobe_count), 32'd3);
    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
